// File: rtl/sbox_sched.sv
// Round-robin scheduler sharing one combinational S-box between a 128-bit
// state job (A, fwd/inv) and a 32-bit SubWord job (B, forward only).
module sbox_sched #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req,
  input  logic         a_inv,
  input  logic [127:0] a_din,
  output logic         a_ack,
  output logic [127:0] a_dout,
  input  logic         b_req,
  input  logic [31:0]  b_din,
  output logic         b_ack,
  output logic [31:0]  b_dout,
  output logic [7:0]   sb_add,
  output logic         sb_inv,
  input  logic [7:0]   sb_dout,
  output logic         busy
);

  // Handshake: req is a level held until the one-cycle ack pulse in DONE;
  // din/inv are captured on the grant edge only, so later changes are ignored,
  // and a req still high when the FSM returns to IDLE is a fresh request.
  typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, DONE} state_t;

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic         rr;       // 0 = A favoured on a tie
  logic         side_b;   // side served by the current/last job
  logic         inv;
  logic [127:0] work;
  logic [127:0] work_upd;
  logic         grant_a, grant_b, run;

  assign run = (state == RUN_A) || (state == RUN_B);

  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        if (a_req && (!b_req || !rr)) begin
          grant_a    = 1'b1;
          state_next = RUN_A;
        end else if (b_req) begin
          grant_b    = 1'b1;
          state_next = RUN_B;
        end
      end
      RUN_A:   if (cnt == 4'd15) state_next = DONE;
      RUN_B:   if (cnt == 4'd3)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Substituted byte is written in place so the final edge can publish the
  // complete result including the byte looked up in that same cycle.
  always_comb begin
    work_upd = work;
    work_upd[{cnt, 3'b000} +: 8] = sb_dout;
  end

  assign sb_add = run ? work[{cnt, 3'b000} +: 8] : 8'd0;
  assign sb_inv = run & inv;
  assign busy   = (state != IDLE);
  assign a_ack  = (state == DONE) && !side_b;
  assign b_ack  = (state == DONE) && side_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rr     <= FIRST_PRIO;
      side_b <= 1'b0;
      inv    <= 1'b0;
      work   <= 128'd0;
      a_dout <= 128'd0;
      b_dout <= 32'd0;
    end else begin
      state <= state_next;
      if (grant_a) begin
        work   <= a_din;
        inv    <= a_inv;
        cnt    <= 4'd0;
        rr     <= 1'b1;
        side_b <= 1'b0;
      end else if (grant_b) begin
        work   <= {96'd0, b_din};
        inv    <= 1'b0;
        cnt    <= 4'd0;
        rr     <= 1'b0;
        side_b <= 1'b1;
      end else if (run) begin
        work <= work_upd;
        cnt  <= cnt + 4'd1;
        if (state_next == DONE) begin
          if (state == RUN_A) a_dout <= work_upd;
          else                b_dout <= work_upd[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_sbox_sched.sv
// Bench for sbox_sched: provides the S-box from GF(2^8) arithmetic and checks
// every cycle of each job against an expected-result and arbitration model.
module tb_sbox_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_req, a_inv, a_ack;
  logic [127:0] a_din, a_dout;
  logic         b_req, b_ack;
  logic [31:0]  b_din, b_dout;
  logic [7:0]   sb_add, sb_dout;
  logic         sb_inv, busy;

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_a;
  logic [31:0]  exp_b;
  bit           rr_m;   // side favoured on a tie: 0 = A

  always #5 clk = ~clk;

  assign sb_dout = sb_inv ? inv_tab[sb_add] : fwd_tab[sb_add];

  sbox_sched #(.FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_inv(a_inv), .a_din(a_din), .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_din(b_din), .b_ack(b_ack), .b_dout(b_dout),
    .sb_add(sb_add), .sb_inv(sb_inv), .sb_dout(sb_dout), .busy(busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] b, s, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb = x[7:0];
      b  = 8'd0;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (gmul(xb, yb) == 8'd1) b = yb;
      end
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = xb;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One job from grant to the IDLE cycle after ack; entered at a negedge with
  // the DUT idle (or about to grant this side), returns at a negedge in IDLE.
  task automatic serve(input bit sb, input logic [127:0] din, input bit inv, input bit early_drop);
    int           n;
    logic [127:0] exp;
    logic [7:0]   x;
    n   = sb ? 4 : 16;
    exp = 128'd0;
    for (int k = 0; k < n; k++) begin
      x = din[8*k +: 8];
      exp[8*k +: 8] = (inv && !sb) ? inv_tab[x] : fwd_tab[x];
    end
    if (sb) begin b_din = din[31:0]; b_req = 1'b1; end
    else begin a_din = din; a_inv = inv; a_req = 1'b1; end
    rr_m = !sb;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("run_busy", busy, 1'b1);
      chk("run_sb_add", sb_add, din[8*k +: 8]);
      chk("run_sb_inv", sb_inv, inv && !sb);
      chk("run_a_ack", a_ack, 1'b0);
      chk("run_b_ack", b_ack, 1'b0);
      chk("run_a_hold", a_dout, exp_a);
      chk("run_b_hold", b_dout, exp_b);
      if (k == 0) begin
        if (sb) begin
          b_din = $urandom;
          if (early_drop) b_req = 1'b0;
        end else begin
          a_din = rand128();
          a_inv = !inv;
          if (early_drop) a_req = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("done_a_ack", a_ack, !sb);
    chk("done_b_ack", b_ack, sb);
    chk("done_busy", busy, 1'b1);
    chk("done_sb_add", sb_add, 8'd0);
    chk("done_sb_inv", sb_inv, 1'b0);
    if (sb) begin
      exp_b = exp[31:0];
      b_req = 1'b0;
    end else begin
      exp_a = exp;
      a_req = 1'b0;
    end
    chk("done_a_dout", a_dout, exp_a);
    chk("done_b_dout", b_dout, exp_b);
    @(negedge clk);
    chk("idle_a_ack", a_ack, 1'b0);
    chk("idle_b_ack", b_ack, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_sb_add", sb_add, 8'd0);
  endtask

  task automatic serve_both(input logic [127:0] da, input bit ia, input logic [31:0] db, input bit drop);
    if (!rr_m) begin
      b_din = db; b_req = 1'b1;
      serve(1'b0, da, ia, drop);
      serve(1'b1, {96'd0, db}, 1'b0, drop);
    end else begin
      a_din = da; a_inv = ia; a_req = 1'b1;
      serve(1'b1, {96'd0, db}, 1'b0, drop);
      serve(1'b0, da, ia, drop);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_ack"}, a_ack, 1'b0);
    chk({tag, "_b_ack"}, b_ack, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_sb_add"}, sb_add, 8'd0);
    chk({tag, "_sb_inv"}, sb_inv, 1'b0);
    chk({tag, "_a_dout"}, a_dout, 128'd0);
    chk({tag, "_b_dout"}, b_dout, 32'd0);
  endtask

  initial begin
    logic [127:0] keep_a;
    int           mode;
    rst_n = 1'b0;
    a_req = 1'b0; a_inv = 1'b0; a_din = 128'd0;
    b_req = 1'b0; b_din = 32'd0;
    exp_a = 128'd0; exp_b = 32'd0; rr_m = 1'b0;
    build_tables();

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // A forward on zero, A inverse back to zero, B SubWord
    serve(1'b0, 128'd0, 1'b0, 1'b0);
    chk("tp_a_fwd", a_dout, {16{8'h63}});
    serve(1'b0, {16{8'h63}}, 1'b1, 1'b0);
    chk("tp_a_inv", a_dout, 128'd0);
    serve(1'b1, {96'd0, 32'h00010253}, 1'b0, 1'b0);
    chk("tp_b_word", b_dout, 32'h637C77ED);

    // Simultaneous requests twice: A, B, then A again
    serve_both(rand128(), 1'b0, $urandom, 1'b0);
    keep_a = exp_a;
    serve_both(rand128(), 1'b1, $urandom, 1'b0);
    chk("tp_both_a_changed", a_dout == keep_a, 1'b0);

    // Reset in the middle of an A job
    a_din = rand128(); a_inv = 1'b0; a_req = 1'b1;
    repeat (9) @(negedge clk);
    chk("mid_cnt8_sb_add", sb_add, a_din[71:64]);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    a_req = 1'b0;
    exp_a = 128'd0; exp_b = 32'd0; rr_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_ack", a_ack | b_ack, 1'b0);
      chk("post_reset_idle", busy, 1'b0);
    end
    serve(1'b0, {16{8'h53}}, 1'b0, 1'b0);
    chk("tp_rereq", a_dout, {16{8'hED}});

    // Randomized mix of single and contending jobs
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0)      serve(1'b0, rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (mode == 1) serve(1'b1, {96'd0, 32'($urandom)}, 1'b0, 1'($urandom_range(0, 1)));
      else                serve_both(rand128(), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Time-multiplexes one combinational S-box instance (subBytes: add[7:0] in, invbytes in, dout[7:0] out) between two requesters.
- Requester A: full 128-bit state SubBytes / InvSubBytes, 16 lookups.
- Requester B: key-expansion SubWord on a 32-bit word, 4 lookups, forward only.
- Sits between the round datapath / key schedule and the single shared S-box, one byte per cycle, round-robin arbitration.

Parameters:
- FIRST_PRIO, 0, initial round-robin pointer after reset (0 = A favoured, 1 = B favoured).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  state job request; held high until a_ack
- a_inv  in  1  1 = InvSubBytes; sampled at grant
- a_din  in  128  state in; byte k = bits [8k+7:8k]; sampled at grant
- a_ack  out  1  one-cycle done pulse
- a_dout  out  128  substituted state, registered
- b_req  in  1  SubWord request; held high until b_ack
- b_din  in  32  word in; byte k = bits [8k+7:8k]; sampled at grant
- b_ack  out  1  one-cycle done pulse
- b_dout  out  32  substituted word, registered
- sb_add  out  8  to subBytes add
- sb_inv  out  1  to subBytes invbytes
- sb_dout  in  8  from subBytes dout (combinational, same-cycle)
- busy  out  1  high in RUN_A, RUN_B, DONE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; byte counter = 0; rr pointer = FIRST_PRIO.
  - a_ack, b_ack, busy, sb_add and sb_inv all 0.
  - a_dout and b_dout cleared to 0.
  - Any in-flight job is discarded with no ack; the requester must re-request.
- FSM states: IDLE, RUN_A, RUN_B, DONE.
- IDLE:
  - Only a_req: go to RUN_A.
  - Only b_req: go to RUN_B.
  - Both high: grant the side the rr pointer favours.
  - The grant edge latches din into the work register, latches a_inv (B forces inv = 0), clears the counter, and sets the pointer to favour the other side.
- RUN_x:
  - sb_add = work byte[cnt]; sb_inv = latched inv.
  - Each edge stores sb_dout into result byte[cnt] and increments cnt.
  - On the edge storing the last byte (cnt 15 for A, 3 for B), go to DONE.
- DONE (exactly one cycle):
  - Assert the served side's ack.
  - a_dout or b_dout is loaded on the edge entering DONE and is valid while ack is high.
  - Next state is IDLE unconditionally.
- Latency: with grant edge E0, a_ack is high in the cycle after E16; b_ack is high in the cycle after E4.
- Minimum gap between jobs is one IDLE cycle.
- Output hold: a_dout and b_dout hold their value until that side's next completion; the other side's job never disturbs them.
- Handshake:
  - The requester drops req on the edge where it sees ack.
  - If req is still high in IDLE, it is treated as a new request.
- Dropping req mid-job does not abort the job; ack still pulses.
- Changing din or a_inv after grant has no effect on the job.
- Outside RUN_x: sb_add = 0, sb_inv = 0.
- a_ack and b_ack are never high in the same cycle.
- A waiting requester is served at most one job late (round-robin, no starvation).

Test Plan:
- A fwd, a_din = 128'h0: a_dout = {16{8'h63}}; a_ack high exactly 16 edges after grant, width 1 cycle; busy high throughout.
- A inv, a_din = {16{8'h63}}: a_dout = 128'h0; sb_inv = 1 during RUN_A only.
- B, b_din = 32'h00010253: b_dout = 32'h637C77ED; b_ack 4 edges after grant; sb_inv = 0.
- a_req and b_req rise together, FIRST_PRIO = 0: A granted at E0, a_ack after E16, B granted at E18, b_ack after E22.
- Both requests repeated immediately after: A is served again because the pointer flipped after B; a_dout from the first job is unchanged through the B job.
- rst_n pulsed low at cycle 8 of RUN_A: all outputs 0 immediately, no ack; re-request with a_din = {16{8'h53}} gives a_dout = {16{8'hED}}.
